// File: rtl/alu_2_pkg.sv
// alu_2_pkg: shared types and constants for the sequential 8-bit ALU.
//   - state_e   : controller states IDLE .. DONE
//   - opcode_t  : 2-bit opcode with OP_ADD / OP_SUB / OP_MUL / OP_DIV
//   - WIDTH     : operand width, ITER : iterations for mul/div
//   - is_iter_op: true for opcodes handled by the iterative datapath
// Optional feature macro used elsewhere in this slice: ALU2_SAT_EN.
package alu_2_pkg;

  localparam int WIDTH = 8;
  localparam int ITER  = 8;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    OUT_LO = 3'd4,
    OUT_HI = 3'd5,
    DONE   = 3'd6
  } state_e;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_ADD = 2'd0;
  localparam opcode_t OP_SUB = 2'd1;
  localparam opcode_t OP_MUL = 2'd2;
  localparam opcode_t OP_DIV = 2'd3;

  // mul and div share the upper opcode bit
  function automatic logic is_iter_op(opcode_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_2_if.sv
// alu_2_if: operand/result bus between a controller and the ALU.
//   inbus  : operand byte (A, then B on the next cycle)
//   op     : opcode, taken by the ALU while loading B
//   Begin  : start request (level)
//   outbus : registered result byte from the ALU
// Modports: master = controller side, slave = ALU side.
interface alu_2_if;
  import alu_2_pkg::*;

  logic [WIDTH-1:0] inbus;
  opcode_t          op;
  logic             Begin;
  logic [WIDTH-1:0] outbus;

  modport master (output inbus, output op, output Begin, input outbus);
  modport slave  (input inbus, input op, input Begin, output outbus);

endinterface

// File: rtl/alu_2_iter_unit.sv
// alu_2_iter_unit: shared iterative datapath for multiply (shift-add,
// multiplier LSB first) and divide (restoring).
//   CLk    : rising-edge clock
//   RST    : synchronous active-low reset
//   run    : high for exactly ITER consecutive cycles per operation
//   opcode : OP_MUL or OP_DIV (bit 1 set)
//   a, b   : operands, stable while run is high
//   done   : high during the last iteration cycle
//   result : {hi, lo}; mul -> product, div -> {remainder, quotient}
// The first run cycle seeds the working registers from a/b directly, so
// all ITER iterations fit inside the ITER run cycles.
module alu_2_iter_unit
  import alu_2_pkg::*;
(
  input  logic               CLk,
  input  logic               RST,
  input  logic               run,
  input  opcode_t            opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] cur_hi;
  logic [WIDTH-1:0] cur_lo;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // iteration 0 starts from hi=0 and lo=multiplier (mul) or dividend (div)
    cur_hi  = (cnt_q == '0) ? '0 : hi_q;
    cur_lo  = (cnt_q == '0) ? ((opcode == OP_MUL) ? b : a) : lo_q;
    sum     = {1'b0, cur_hi} + {1'b0, a};
    shifted = {cur_hi, cur_lo[WIDTH-1]};
    // only used when shifted >= b, where the true difference fits in WIDTH bits
    diff    = shifted[WIDTH-1:0] - b;

    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = '0;
    if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (opcode == OP_MUL) begin
        // add multiplicand into the high half when the current bit is set,
        // then shift the whole {carry, hi, lo} right by one
        if (cur_lo[0]) begin
          {hi_d, lo_d} = {sum, cur_lo[WIDTH-1:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, cur_hi, cur_lo[WIDTH-1:1]};
        end
      end else begin
        // with b=0 the compare always succeeds: quotient fills with ones and
        // the remainder ends up holding the dividend after WIDTH shifts
        if (shifted >= {1'b0, b}) begin
          hi_d = diff;
          lo_d = {cur_lo[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shifted[WIDTH-1:0];
          lo_d = {cur_lo[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge CLk) begin
    if (!RST) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign done   = run && (cnt_q == CNT_W'(ITER - 1));
  assign result = {hi_q, lo_q};

endmodule

// File: rtl/alu_2.sv
// alu_2: sequential 8-bit ALU (add, sub, mul, div).
//   CLk  : rising-edge clock
//   RST  : synchronous active-low reset, clears all state
//   bus  : alu_2_if.slave -- inbus/op/Begin in, registered outbus out
// Flow: IDLE -> LOAD_A -> LOAD_B -> EXEC -> OUT_LO -> OUT_HI -> DONE.
// add/sub spend one cycle in EXEC; mul/div spend ITER cycles in the
// alu_2_iter_unit. outbus shows the low byte, then the high byte, and holds
// the high byte in DONE until Begin drops.
// Optional macro ALU2_SAT_EN: saturating add/sub low byte.
module alu_2
  import alu_2_pkg::*;
(
  input  logic CLk,
  input  logic RST,
  alu_2_if.slave bus
);

  state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  opcode_t            opcode_q, opcode_d;
  logic [2*WIDTH-1:0] addsub_q, addsub_d;
  logic [WIDTH-1:0]   outbus_q, outbus_d;

  logic               iter_run;
  logic               iter_done;
  logic [2*WIDTH-1:0] iter_result;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH-1:0]   addsub_lo;
  logic               addsub_flag;
  logic [2*WIDTH-1:0] result_sel;

  alu_2_iter_unit u_iter (
    .CLk    (CLk),
    .RST    (RST),
    .run    (iter_run),
    .opcode (opcode_q),
    .a      (a_q),
    .b      (b_q),
    .done   (iter_done),
    .result (iter_result)
  );

  // add/sub: the 9th bit is carry for add and borrow (a<b) for sub
  always_comb begin
    add_sum  = {1'b0, a_q} + {1'b0, b_q};
    sub_diff = {1'b0, a_q} - {1'b0, b_q};
    if (opcode_q == OP_ADD) begin
      addsub_flag = add_sum[WIDTH];
      addsub_lo   = add_sum[WIDTH-1:0];
`ifdef ALU2_SAT_EN
      if (addsub_flag) begin
        addsub_lo = '1;
      end
`endif
    end else begin
      addsub_flag = sub_diff[WIDTH];
      addsub_lo   = sub_diff[WIDTH-1:0];
`ifdef ALU2_SAT_EN
      if (addsub_flag) begin
        addsub_lo = '0;
      end
`endif
    end
  end

  assign result_sel = is_iter_op(opcode_q) ? iter_result : addsub_q;

  // state register
  always_ff @(posedge CLk) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; Begin is only looked at in IDLE and DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.Begin) state_d = LOAD_A;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = EXEC;
      EXEC:    if (!is_iter_op(opcode_q) || iter_done) state_d = OUT_LO;
      OUT_LO:  state_d = OUT_HI;
      OUT_HI:  state_d = DONE;
      DONE:    if (!bus.Begin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output / datapath-control logic
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    opcode_d = opcode_q;
    addsub_d = addsub_q;
    outbus_d = '0;
    iter_run = 1'b0;
    unique case (state_q)
      LOAD_A: a_d = bus.inbus;
      LOAD_B: begin
        b_d      = bus.inbus;
        opcode_d = bus.op;
      end
      EXEC: begin
        iter_run = is_iter_op(opcode_q);
        addsub_d = {{(WIDTH-1){1'b0}}, addsub_flag, addsub_lo};
      end
      OUT_LO:  outbus_d = result_sel[WIDTH-1:0];
      OUT_HI:  outbus_d = result_sel[2*WIDTH-1:WIDTH];
      DONE:    outbus_d = outbus_q;
      default: outbus_d = '0;
    endcase
  end

  always_ff @(posedge CLk) begin
    if (!RST) begin
      a_q      <= '0;
      b_q      <= '0;
      opcode_q <= OP_ADD;
      addsub_q <= '0;
      outbus_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      opcode_q <= opcode_d;
      addsub_q <= addsub_d;
      outbus_q <= outbus_d;
    end
  end

  assign bus.outbus = outbus_q;

endmodule

// File: tb/tb_alu_2.sv
// tb_alu_2: self-checking bench for alu_2. Directed cases followed by random
// operands/opcodes, compared against an arithmetic reference model.
module tb_alu_2;
  import alu_2_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  alu_2_if u_if ();

  alu_2 dut (
    .CLk (clk),
    .RST (rst_n),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: plain unsigned arithmetic, returns {hi, lo}
  function automatic logic [15:0] model(input int a, input int b, input int o);
    int lo;
    int hi;
    case (o)
      0: begin
        lo = (a + b) % 256;
        hi = (a + b > 255) ? 1 : 0;
`ifdef ALU2_SAT_EN
        if (hi == 1) lo = 255;
`endif
      end
      1: begin
        lo = (a - b + 256) % 256;
        hi = (a < b) ? 1 : 0;
`ifdef ALU2_SAT_EN
        if (hi == 1) lo = 0;
`endif
      end
      2: begin
        lo = (a * b) % 256;
        hi = (a * b) / 256;
      end
      default: begin
        if (b == 0) begin
          lo = 255;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
    return 16'(hi * 256 + lo);
  endfunction

  // One complete transaction; drop=1 releases Begin right after it is sampled.
  task automatic run_op(input int a, input int b, input int o, input bit drop, input string name);
    logic [15:0] exp;
    logic [7:0]  got_lo;
    logic [7:0]  got_hi;
    int          lat;
    exp = model(a, b, o);
    lat = (o < 2) ? 4 : 11;
    u_if.Begin = 1'b1;
    u_if.inbus = 8'($urandom);
    u_if.op    = 2'($urandom);
    tick();                               // Begin sampled, -> LOAD_A
    u_if.inbus = 8'(a);
    u_if.op    = 2'($urandom);            // must be ignored
    if (drop) u_if.Begin = 1'b0;
    tick();                               // A loaded
    u_if.inbus = 8'(b);
    u_if.op    = 2'(o);
    tick();                               // B and op loaded
    u_if.inbus = 8'($urandom);
    u_if.op    = 2'($urandom);
    repeat (lat - 3) tick();
    check({name, ".pre"}, u_if.outbus, 8'h00);
    tick();
    got_lo = u_if.outbus;
    check({name, ".lo"}, got_lo, exp[7:0]);
    tick();
    got_hi = u_if.outbus;
    check({name, ".hi"}, got_hi, exp[15:8]);
    tick();
    check({name, ".hold"}, u_if.outbus, exp[15:8]);
    if (!drop) begin
      tick();                             // Begin still high: no restart
      check({name, ".hold2"}, u_if.outbus, exp[15:8]);
    end
    u_if.Begin = 1'b0;
    tick();
    tick();
    check({name, ".idle"}, u_if.outbus, 8'h00);
    $display("txn %s a=%0d b=%0d op=%0d drop=%0d lo=0x%02h hi=0x%02h", name, a, b, o, drop, got_lo, got_hi);
  endtask

  initial begin
    u_if.Begin = 1'b0;
    u_if.inbus = 8'h00;
    u_if.op    = 2'd0;
    rst_n      = 1'b0;

    // reset state
    repeat (3) tick();
    check("reset.out", u_if.outbus, 8'h00);
    rst_n = 1'b1;
    tick();
    check("reset.idle", u_if.outbus, 8'h00);

    // directed cases
    run_op(24, 31, 0, 1'b0, "add");
    run_op(25, 16, 1, 1'b0, "sub");
    run_op(16, 25, 1, 1'b1, "sub_borrow");
    run_op(200, 100, 0, 1'b0, "add_carry");
    run_op(25, 16, 2, 1'b0, "mul");
    run_op(255, 255, 2, 1'b1, "mul_max");
    run_op(200, 7, 3, 1'b0, "div");
    run_op(77, 0, 3, 1'b0, "div_zero");

    // reset in the middle of a multiply
    u_if.Begin = 1'b1;
    tick();
    u_if.inbus = 8'd99;
    tick();
    u_if.inbus = 8'd77;
    u_if.op    = 2'd2;
    tick();
    u_if.Begin = 1'b0;
    repeat (4) tick();                    // inside EXEC
    rst_n = 1'b0;
    tick();
    check("rst_exec.out", u_if.outbus, 8'h00);
    rst_n = 1'b1;
    repeat (12) tick();                   // an unaborted mul would have shown bytes by now
    check("rst_exec.quiet", u_if.outbus, 8'h00);
    $display("txn rst_exec outbus=0x%02h", u_if.outbus);
    run_op(25, 16, 2, 1'b0, "mul_after_rst");

    // reset while a result byte is on outbus
    u_if.Begin = 1'b1;
    tick();
    u_if.inbus = 8'd200;
    tick();
    u_if.inbus = 8'd100;
    u_if.op    = 2'd0;
    tick();
    tick();
    tick();
    check("rst_out.lo", u_if.outbus, model(200, 100, 0) >> 0 & 16'h00FF);
    rst_n = 1'b0;
    u_if.Begin = 1'b0;
    tick();
    check("rst_out.clr", u_if.outbus, 8'h00);
    rst_n = 1'b1;
    tick();
    tick();
    check("rst_out.idle", u_if.outbus, 8'h00);
    $display("txn rst_out outbus=0x%02h", u_if.outbus);
    run_op(16, 25, 1, 1'b0, "sub_after_rst");

    // random operands and opcodes
    for (int i = 0; i < 40; i++) begin
      int ra;
      int rb;
      int ro;
      ra = int'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      ro = int'($urandom_range(0, 3));
      run_op(ra, rb, ro, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
